// File: rtl/axi_rd_master.sv
// AXI4 read master: one INCR burst per user request, R beats returned through
// a one-entry output register with user backpressure.
// Optional build macro: AXI_RD_ERR_CHK_EN enables the sticky R-channel checker
// driving axi_rd_err; without it axi_rd_err is tied low.
module axi_rd_master #(
    parameter int unsigned AXI_DATA_WIDTH = 128,
    parameter int unsigned AXI_ADDR_WIDTH = 32
) (
    input  logic                      axi_clk,
    input  logic                      reset_n,
    // AR channel
    output logic [3:0]                m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    // R channel
    input  logic [3:0]                m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    // user request side
    output logic                      axi_ar_ready,
    input  logic                      axi_ar_req_en,
    input  logic [7:0]                axi_ar_burst_len,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
    // user data side
    output logic [AXI_DATA_WIDTH-1:0] axi_r_data,
    output logic                      axi_r_valid,
    output logic                      axi_r_last,
    input  logic                      axi_r_ready,
    output logic                      axi_rd_err
);

    localparam logic [2:0] AR_SIZE =
        (AXI_DATA_WIDTH == 512) ? 3'd6 :
        (AXI_DATA_WIDTH == 256) ? 3'd5 :
        (AXI_DATA_WIDTH == 128) ? 3'd4 :
        (AXI_DATA_WIDTH == 64)  ? 3'd3 :
        (AXI_DATA_WIDTH == 32)  ? 3'd2 : 3'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_PRE  = 2'd1,
        RD_DATA = 2'd2,
        RD_END  = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] beat_cnt;
    logic       r_hs;

    // Fixed AR sideband: single INCR burst, id 0, no lock/cache/prot/qos
    assign m_axi_arid    = 4'd0;
    assign m_axi_arsize  = AR_SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;

    // Request slot and R acceptance; a held beat blocks the slave until popped
    assign axi_ar_ready = (state == RD_PRE);
    assign m_axi_rready = (state == RD_DATA) && (!axi_r_valid || axi_r_ready);
    assign r_hs         = m_axi_rvalid && m_axi_rready;

    // Burst FSM, AR channel registers and beat counter
    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= 8'd0;
            beat_cnt      <= 8'd0;
        end else begin
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_arvalid <= 1'b0;
            end

            if (state == RD_PRE) begin
                beat_cnt <= 8'd0;
            end else if (r_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (axi_ar_req_en) begin
                        state <= RD_PRE;
                    end
                end
                RD_PRE: begin
                    if (axi_ar_req_en) begin
                        state         <= RD_DATA;
                        m_axi_araddr  <= axi_ar_addr;
                        m_axi_arlen   <= axi_ar_burst_len;
                        m_axi_arvalid <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RD_DATA: begin
                    if (r_hs && m_axi_rlast) begin
                        state <= RD_END;
                    end
                end
                RD_END: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // One-entry output register; reload and pop in the same cycle keeps full rate
    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            axi_r_data  <= '0;
            axi_r_valid <= 1'b0;
            axi_r_last  <= 1'b0;
        end else if (r_hs) begin
            axi_r_data  <= m_axi_rdata;
            axi_r_last  <= m_axi_rlast;
            axi_r_valid <= 1'b1;
        end else if (axi_r_valid && axi_r_ready) begin
            axi_r_valid <= 1'b0;
            axi_r_last  <= 1'b0;
        end
    end

`ifdef AXI_RD_ERR_CHK_EN
    // Sticky checker: bad response, foreign id, or rlast not on the arlen-th beat
    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            axi_rd_err <= 1'b0;
        end else if (r_hs && ((m_axi_rresp != 2'b00) ||
                              (m_axi_rid != 4'd0) ||
                              (m_axi_rlast && (beat_cnt != m_axi_arlen)) ||
                              (!m_axi_rlast && (beat_cnt == m_axi_arlen)))) begin
            axi_rd_err <= 1'b1;
        end
    end
`else
    // Checker not built: flag held low, checker inputs intentionally unused
    logic unused_chk;
    assign unused_chk = ^{m_axi_rid, m_axi_rresp, beat_cnt};
    assign axi_rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_master.sv
// Bench for axi_rd_master: behavioural AXI slave plus a queue-based model of
// the beats the user side must see, directed cases then randomized bursts.
module tb_axi_rd_master;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 32;
`ifdef AXI_RD_ERR_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          axi_clk;
    logic          reset_n;
    logic [3:0]    m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arlock;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic [3:0]    m_axi_arqos;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [3:0]    m_axi_rid;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic          axi_ar_ready;
    logic          axi_ar_req_en;
    logic [7:0]    axi_ar_burst_len;
    logic [AW-1:0] axi_ar_addr;
    logic [DW-1:0] axi_r_data;
    logic          axi_r_valid;
    logic          axi_r_last;
    logic          axi_r_ready;
    logic          axi_rd_err;

    axi_rd_master #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
        .axi_clk(axi_clk), .reset_n(reset_n),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .axi_ar_ready(axi_ar_ready), .axi_ar_req_en(axi_ar_req_en),
        .axi_ar_burst_len(axi_ar_burst_len), .axi_ar_addr(axi_ar_addr),
        .axi_r_data(axi_r_data), .axi_r_valid(axi_r_valid), .axi_r_last(axi_r_last),
        .axi_r_ready(axi_r_ready), .axi_rd_err(axi_rd_err)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } burst_t;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // slave model state
    burst_t       s_q[$];
    int           s_beat = 0;
    int           ar_stall = 0;
    bit           rnd_ar = 0;
    bit           rnd_r = 0;
    int           err_resp_beat = -1;
    int           early_last = -1;
    // user side and reference model
    int           u_mode = 0;
    bit           tog = 0;
    logic [128:0] exp_q[$];
    logic [31:0]  req_addr_m = '0;
    int           req_len_m = 0;
    int           ar_hi_cnt = 0;
    bit           last_accept = 0;
    bit           prev_rhs = 0;
    logic [127:0] prev_rdata = '0;
    logic         prev_rlast = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Payload the slave returns for beat i of a burst at address a
    function automatic logic [127:0] beat_data(input logic [31:0] a, input int i);
        logic [31:0] iv;
        iv = 32'(i);
        if (a == 32'h0000_1000) return {16{8'hA5}};
        return {a ^ iv, ~a + iv, a + (iv * 32'd7), iv ^ 32'hC0DE_0000};
    endfunction

    // One clock: drive at edge+1, observe handshakes at edge+8, advance to next edge+1
    task automatic step();
        logic [128:0] e;
        int           n;
        burst_t       b;
        if (prev_rhs) begin
            check_eq("r_valid_latency", 128'(axi_r_valid), 128'(1));
            check_eq("r_data_latency", axi_r_data, prev_rdata);
            check_eq("r_last_latency", 128'(axi_r_last), 128'(prev_rlast));
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
        end
        if (m_axi_arvalid) begin
            if (ar_stall > 0) begin
                m_axi_arready = 1'b0;
                ar_stall--;
            end else begin
                m_axi_arready = rnd_ar ? 1'($urandom % 2) : 1'b1;
            end
        end else begin
            m_axi_arready = 1'b0;
        end
        if (!m_axi_rvalid && s_q.size() > 0 && (!rnd_r || ($urandom % 4) != 0)) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = beat_data(s_q[0].addr, s_beat);
            m_axi_rlast  = (early_last >= 0) ? (s_beat == early_last) : (s_beat == s_q[0].len);
            m_axi_rresp  = (s_beat == err_resp_beat) ? 2'b10 : 2'b00;
        end
        case (u_mode)
            0: axi_r_ready = 1'b1;
            1: axi_r_ready = 1'($urandom % 2);
            default: begin
                tog = ~tog;
                axi_r_ready = tog;
            end
        endcase

        #7;
        if (axi_r_valid && !axi_r_ready)
            check_eq("rready_while_held", 128'(m_axi_rready), 128'(0));
        if (m_axi_arvalid) begin
            ar_hi_cnt++;
            check_eq("araddr", 128'(m_axi_araddr), 128'(req_addr_m));
            check_eq("arlen", 128'(m_axi_arlen), 128'(req_len_m));
            if (m_axi_arready) begin
                b.addr = m_axi_araddr;
                b.len  = int'(m_axi_arlen);
                s_q.push_back(b);
                n = (early_last >= 0) ? early_last + 1 : req_len_m + 1;
                for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, beat_data(req_addr_m, i)});
            end
        end
        prev_rhs = m_axi_rvalid && m_axi_rready;
        if (prev_rhs) begin
            prev_rdata = m_axi_rdata;
            prev_rlast = m_axi_rlast;
            s_beat++;
            if (m_axi_rlast) begin
                void'(s_q.pop_front());
                s_beat = 0;
            end
        end
        if (axi_r_valid && axi_r_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_beat", 128'(1), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("r_data", axi_r_data, e[127:0]);
                check_eq("r_last", 128'(axi_r_last), 128'(e[128]));
            end
        end
        last_accept = axi_ar_ready && axi_ar_req_en;
        if (last_accept) begin
            req_addr_m = axi_ar_addr;
            req_len_m  = int'(axi_ar_burst_len);
            ar_hi_cnt  = 0;
        end
        @(posedge axi_clk);
        #1;
    endtask

    task automatic clear_model();
        s_q.delete();
        exp_q.delete();
        s_beat       = 0;
        prev_rhs     = 0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
        m_axi_arready = 1'b0;
        axi_ar_req_en = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        clear_model();
        repeat (2) @(posedge axi_clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic do_burst(input logic [31:0] addr, input int len);
        axi_ar_addr      = addr;
        axi_ar_burst_len = 8'(len);
        axi_ar_req_en    = 1'b1;
        last_accept      = 0;
        for (int i = 0; i < 50 && !last_accept; i++) step();
        if (!last_accept) check_eq("accept_timeout", 128'(0), 128'(1));
        axi_ar_req_en = 1'b0;
        axi_ar_addr   = $urandom;
    endtask

    task automatic wait_done(input bit drain);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (s_q.size() == 0 && !m_axi_rvalid && !m_axi_arvalid &&
                (!drain || (exp_q.size() == 0 && !axi_r_valid))) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) check_eq("done_timeout", 128'(0), 128'(1));
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        axi_ar_req_en = 1'b0; axi_ar_burst_len = 8'd0; axi_ar_addr = '0;
        axi_r_ready = 1'b0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rid = 4'd0;
        #2;
        // reset values
        check_eq("rst_arvalid", 128'(m_axi_arvalid), 128'(0));
        check_eq("rst_r_valid", 128'(axi_r_valid), 128'(0));
        check_eq("rst_r_last", 128'(axi_r_last), 128'(0));
        check_eq("rst_rd_err", 128'(axi_rd_err), 128'(0));
        check_eq("rst_r_data", axi_r_data, 128'(0));
        check_eq("rst_araddr", 128'(m_axi_araddr), 128'(0));
        check_eq("rst_arlen", 128'(m_axi_arlen), 128'(0));
        check_eq("rst_arsize", 128'(m_axi_arsize), 128'(4));
        check_eq("rst_arburst", 128'(m_axi_arburst), 128'(1));
        check_eq("rst_sideband", 128'({m_axi_arid, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos}), 128'(0));
        check_eq("rst_ar_ready", 128'(axi_ar_ready), 128'(0));
        check_eq("rst_rready", 128'(m_axi_rready), 128'(0));
        repeat (2) @(posedge axi_clk);
        #1;
        reset_n = 1'b1;

        // single beat, directed timing
        axi_ar_addr = 32'h0000_1000; axi_ar_burst_len = 8'd0; axi_ar_req_en = 1'b1;
        step();
        check_eq("t1_ar_ready_pre", 128'(axi_ar_ready), 128'(1));
        check_eq("t1_arvalid_pre", 128'(m_axi_arvalid), 128'(0));
        step();
        axi_ar_req_en = 1'b0;
        check_eq("t1_arvalid", 128'(m_axi_arvalid), 128'(1));
        check_eq("t1_araddr", 128'(m_axi_araddr), 128'h1000);
        check_eq("t1_arlen", 128'(m_axi_arlen), 128'(0));
        check_eq("t1_arsize", 128'(m_axi_arsize), 128'(4));
        wait_done(1);
        check_eq("t1_ar_ready_idle", 128'(axi_ar_ready), 128'(0));

        // 16 beats with arready held off 3 cycles
        ar_stall = 3;
        do_burst(32'h0000_2000, 15);
        wait_done(1);
        check_eq("t2_arvalid_cycles", 128'(ar_hi_cnt), 128'(4));

        // user ready toggling, slave always valid
        u_mode = 2;
        do_burst(32'h0000_3000, 7);
        wait_done(1);
        u_mode = 0;

        // request dropped in RD_PRE: no AR issued
        axi_ar_addr = 32'h0000_4000; axi_ar_req_en = 1'b1;
        step();
        axi_ar_req_en = 1'b0;
        check_eq("t4_ar_ready_pre", 128'(axi_ar_ready), 128'(1));
        step();
        check_eq("t4_ar_ready_idle", 128'(axi_ar_ready), 128'(0));
        check_eq("t4_arvalid_a", 128'(m_axi_arvalid), 128'(0));
        step();
        check_eq("t4_arvalid_b", 128'(m_axi_arvalid), 128'(0));
        check_eq("t4_ar_ready_b", 128'(axi_ar_ready), 128'(0));

        // asynchronous reset mid-burst at beat 5 of 8
        do_burst(32'h0000_5000, 7);
        for (int i = 0; i < 100 && s_beat < 4; i++) step();
        check_eq("t5_reached_beat5", 128'(s_beat), 128'(4));
        reset_n = 1'b0;
        #1;
        check_eq("t5_arvalid", 128'(m_axi_arvalid), 128'(0));
        check_eq("t5_r_valid", 128'(axi_r_valid), 128'(0));
        check_eq("t5_r_last", 128'(axi_r_last), 128'(0));
        check_eq("t5_rready", 128'(m_axi_rready), 128'(0));
        clear_model();
        repeat (2) @(posedge axi_clk);
        #1;
        reset_n = 1'b1;
        do_burst(32'h0000_5800, 3);
        wait_done(1);
        check_eq("t5_rd_err_clean", 128'(axi_rd_err), 128'(0));

        // error response on beat 2, then stickiness
        err_resp_beat = 1;
        do_burst(32'h0000_6000, 3);
        wait_done(1);
        err_resp_beat = -1;
        check_eq("t6_err_rresp", 128'(axi_rd_err), 128'(EXP_ERR));
        do_burst(32'h0000_6400, 2);
        wait_done(1);
        check_eq("t6_err_sticky", 128'(axi_rd_err), 128'(EXP_ERR));
        pulse_reset();
        check_eq("t6_err_cleared", 128'(axi_rd_err), 128'(0));
        // early rlast on beat 3 of an 8-beat request
        early_last = 2;
        do_burst(32'h0000_7000, 7);
        wait_done(1);
        early_last = -1;
        check_eq("t6_err_early_last", 128'(axi_rd_err), 128'(EXP_ERR));
        pulse_reset();

        // randomized back-to-back bursts with random stalls on every side
        rnd_ar = 1; rnd_r = 1; u_mode = 1;
        for (int k = 0; k < 30; k++) begin
            do_burst({$urandom_range(0, 32'h0FFF_FFFF), 4'h0}, int'($urandom_range(0, 15)));
            wait_done(0);
        end
        wait_done(1);
        check_eq("rand_queue_empty", 128'(exp_q.size()), 128'(0));
        check_eq("rand_rd_err", 128'(axi_rd_err), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
